axitrafficgen_axi_master: RTL and testbench

- AXI4 master traffic generator that drives the AXI master port of the axitrafficgen accelerator, which the AXI-to-DMA FIFO bridge converts into ESP DMA transactions.
- On conf_done it writes a programmable number of 64-bit beats with a seeded pattern, reads them back, and optionally checks them.
- It reports completion on acc_done and an error count on debug.

---
 rtl/axitrafficgen_pkg.sv | 26 ++
 rtl/axitrafficgen_axi_master_if.sv | 65 ++++++
 rtl/axitrafficgen_checker.sv | 57 +++++
 rtl/axitrafficgen_axi_master.sv | 206 ++++++++++++++++++++
 tb/tb_axitrafficgen_axi_master.sv | 317 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/axitrafficgen_pkg.sv
// Shared types and constants for the axitrafficgen AXI master traffic generator.
// The state encoding doubles as the code reported in debug[31:28].
package axitrafficgen_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_AW   = 3'd1,
        ST_W    = 3'd2,
        ST_B    = 3'd3,
        ST_AR   = 3'd4,
        ST_R    = 3'd5,
        ST_DONE = 3'd6
    } state_t;

    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [2:0] AXI_SIZE_8B    = 3'b011;

    // Index bits kept from the requested beat count so that i*8 fits 32 bits.
    localparam int IDX_BITS = 29;

    function automatic logic [63:0] pattern(input logic [31:0] seed, input logic [31:0] idx);
        return {seed, idx};
    endfunction

endpackage

// File: rtl/axitrafficgen_axi_master_if.sv
// AXI4 bus bundle between the traffic generator (master) and the DMA bridge (slave).
interface axitrafficgen_axi_master_if #(
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int AXI_DATA_WIDTH = 64,
    parameter int AXI_ID_WIDTH   = 4
) ();
    logic [AXI_ID_WIDTH-1:0]     aw_id;
    logic [AXI_ADDR_WIDTH-1:0]   aw_addr;
    logic [7:0]                  aw_len;
    logic [2:0]                  aw_size;
    logic [1:0]                  aw_burst;
    logic                        aw_valid;
    logic                        aw_ready;

    logic [AXI_DATA_WIDTH-1:0]   w_data;
    logic [AXI_DATA_WIDTH/8-1:0] w_strb;
    logic                        w_last;
    logic                        w_valid;
    logic                        w_ready;

    logic [1:0]                  b_resp;
    logic                        b_valid;
    logic                        b_ready;

    logic [AXI_ID_WIDTH-1:0]     ar_id;
    logic [AXI_ADDR_WIDTH-1:0]   ar_addr;
    logic [7:0]                  ar_len;
    logic [2:0]                  ar_size;
    logic [1:0]                  ar_burst;
    logic                        ar_valid;
    logic                        ar_ready;

    logic [AXI_DATA_WIDTH-1:0]   r_data;
    logic [1:0]                  r_resp;
    logic                        r_last;
    logic                        r_valid;
    logic                        r_ready;

    modport master (
        output aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_valid,
        input  aw_ready,
        output w_data, w_strb, w_last, w_valid,
        input  w_ready,
        input  b_resp, b_valid,
        output b_ready,
        output ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_valid,
        input  ar_ready,
        input  r_data, r_resp, r_last, r_valid,
        output r_ready
    );

    modport slave (
        input  aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_valid,
        output aw_ready,
        input  w_data, w_strb, w_last, w_valid,
        output w_ready,
        output b_resp, b_valid,
        input  b_ready,
        input  ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_valid,
        output ar_ready,
        output r_data, r_resp, r_last, r_valid,
        input  r_ready
    );

endinterface

// File: rtl/axitrafficgen_checker.sv
// Per-beat response/last/data error accounting with a saturating 16-bit counter.
// Data comparison is compiled in only when AXITRAFFICGEN_CHECK_EN is defined.
module axitrafficgen_checker
    import axitrafficgen_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        inc_en,
    input  logic        data_chk,
    input  logic        last_err,
    input  logic [1:0]  resp,
    input  logic [63:0] data,
    input  logic [63:0] expected,
    output logic [15:0] err_cnt
);

    logic [15:0] err_cnt_q, err_cnt_d;
    logic        resp_err;
    logic        data_err;
    logic [1:0]  inc_amt;
    logic [16:0] sum;

    assign resp_err = (resp != AXI_RESP_OKAY);

`ifdef AXITRAFFICGEN_CHECK_EN
    assign data_err = data_chk && (data != expected);
`else
    logic unused_data;
    assign unused_data = ^{data, expected, data_chk};
    assign data_err    = 1'b0;
`endif

    // A single beat can contribute resp, data and last-mismatch errors at once.
    assign inc_amt = {1'b0, resp_err} + {1'b0, data_err} + {1'b0, last_err};
    assign sum     = {1'b0, err_cnt_q} + {15'd0, inc_amt};

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (clr) begin
            err_cnt_d = '0;
        end else if (inc_en) begin
            err_cnt_d = sum[16] ? 16'hFFFF : sum[15:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err_cnt = err_cnt_q;

endmodule

// File: rtl/axitrafficgen_axi_master.sv
// AXI4 traffic generator: writes N seeded 64-bit beats, reads them back and counts errors.
// Define AXITRAFFICGEN_CHECK_EN to also compare read data against the written pattern.
module axitrafficgen_axi_master
    import axitrafficgen_pkg::*;
#(
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int AXI_DATA_WIDTH = 64,
    parameter int AXI_ID_WIDTH   = 4,
    parameter int BURST_BEATS    = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [31:0]               conf_info_reg1,
    input  logic [31:0]               conf_info_reg2,
    input  logic                      conf_done,
    axitrafficgen_axi_master_if.master axi,
    output logic                      acc_done,
    output logic [31:0]               debug
);

    generate
        if (AXI_DATA_WIDTH != 64 || BURST_BEATS < 1 || BURST_BEATS > 256 ||
            (BURST_BEATS & (BURST_BEATS - 1)) != 0 || BURST_BEATS * 8 > 4096) begin : g_bad_cfg
            $error("axitrafficgen_axi_master: unsupported data width or BURST_BEATS");
        end
    endgenerate

    state_t      state_q, state_d;
    logic [31:0] n_q, n_d;
    logic [31:0] seed_q, seed_d;
    logic [31:0] idx_q, idx_d;
    logic [8:0]  len_q, len_d;
    logic [8:0]  cnt_q, cnt_d;
    logic        acc_done_q, acc_done_d;

    logic        err_clr;
    logic        chk_inc;
    logic        chk_data;
    logic        last_err;
    logic [1:0]  chk_resp;
    logic        w_last;
    logic        r_end;
    logic [31:0] idx_inc;
    logic [31:0] n_new;
    logic [15:0] err_cnt;
    logic        unused_conf;

    function automatic logic [8:0] clip_len(input logic [31:0] rem);
        if (rem > 32'(BURST_BEATS)) begin
            return 9'(BURST_BEATS);
        end
        return rem[8:0];
    endfunction

    assign idx_inc     = idx_q + 32'd1;
    assign n_new       = {3'b000, conf_info_reg1[IDX_BITS-1:0]};
    assign unused_conf = ^conf_info_reg1[31:IDX_BITS];
    assign w_last      = (cnt_q == len_q - 9'd1);
    assign r_end       = ((cnt_q + 9'd1) == len_q);

    always_comb begin
        state_d    = state_q;
        n_d        = n_q;
        seed_d     = seed_q;
        idx_d      = idx_q;
        len_d      = len_q;
        cnt_d      = cnt_q;
        err_clr    = 1'b0;
        acc_done_d = (state_q == ST_DONE);

        case (state_q)
            ST_IDLE: begin
                if (conf_done) begin
                    n_d     = n_new;
                    seed_d  = conf_info_reg2;
                    idx_d   = '0;
                    cnt_d   = '0;
                    err_clr = 1'b1;
                    len_d   = clip_len(n_new);
                    state_d = (n_new == 32'd0) ? ST_DONE : ST_AW;
                end
            end
            ST_AW: begin
                if (axi.aw_ready) begin
                    cnt_d   = '0;
                    state_d = ST_W;
                end
            end
            ST_W: begin
                if (axi.w_ready) begin
                    idx_d = idx_inc;
                    cnt_d = cnt_q + 9'd1;
                    if (w_last) begin
                        state_d = ST_B;
                    end
                end
            end
            ST_B: begin
                if (axi.b_valid) begin
                    // Write phase is over once every beat has been sent; restart i for reads.
                    if (idx_q == n_q) begin
                        idx_d   = '0;
                        len_d   = clip_len(n_q);
                        state_d = ST_AR;
                    end else begin
                        len_d   = clip_len(n_q - idx_q);
                        state_d = ST_AW;
                    end
                end
            end
            ST_AR: begin
                if (axi.ar_ready) begin
                    cnt_d   = '0;
                    state_d = ST_R;
                end
            end
            ST_R: begin
                if (axi.r_valid) begin
                    idx_d = idx_inc;
                    cnt_d = cnt_q + 9'd1;
                    // Burst end follows the local beat count; r_last only feeds the error count.
                    if (r_end) begin
                        if (idx_inc == n_q) begin
                            state_d = ST_DONE;
                        end else begin
                            len_d   = clip_len(n_q - idx_inc);
                            state_d = ST_AR;
                        end
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            n_q        <= '0;
            seed_q     <= '0;
            idx_q      <= '0;
            len_q      <= '0;
            cnt_q      <= '0;
            acc_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            n_q        <= n_d;
            seed_q     <= seed_d;
            idx_q      <= idx_d;
            len_q      <= len_d;
            cnt_q      <= cnt_d;
            acc_done_q <= acc_done_d;
        end
    end

    assign chk_inc  = ((state_q == ST_B) && axi.b_valid) || ((state_q == ST_R) && axi.r_valid);
    assign chk_data = (state_q == ST_R);
    assign chk_resp = (state_q == ST_B) ? axi.b_resp : axi.r_resp;
    assign last_err = (state_q == ST_R) && (axi.r_last != r_end);

    axitrafficgen_checker u_checker (
        .clk      (clk),
        .rst      (rst),
        .clr      (err_clr),
        .inc_en   (chk_inc),
        .data_chk (chk_data),
        .last_err (last_err),
        .resp     (chk_resp),
        .data     (axi.r_data),
        .expected (pattern(seed_q, idx_q)),
        .err_cnt  (err_cnt)
    );

    // Every bus output decodes registered state only, so payload is stable until ready.
    assign axi.aw_id    = '0;
    assign axi.aw_addr  = AXI_ADDR_WIDTH'({idx_q[IDX_BITS-1:0], 3'b000});
    assign axi.aw_len   = 8'(len_q - 9'd1);
    assign axi.aw_size  = AXI_SIZE_8B;
    assign axi.aw_burst = AXI_BURST_INCR;
    assign axi.aw_valid = (state_q == ST_AW);

    assign axi.w_data   = pattern(seed_q, idx_q);
    assign axi.w_strb   = '1;
    assign axi.w_last   = w_last;
    assign axi.w_valid  = (state_q == ST_W);

    assign axi.b_ready  = (state_q == ST_B);

    assign axi.ar_id    = '0;
    assign axi.ar_addr  = AXI_ADDR_WIDTH'({idx_q[IDX_BITS-1:0], 3'b000});
    assign axi.ar_len   = 8'(len_q - 9'd1);
    assign axi.ar_size  = AXI_SIZE_8B;
    assign axi.ar_burst = AXI_BURST_INCR;
    assign axi.ar_valid = (state_q == ST_AR);

    assign axi.r_ready  = (state_q == ST_R);

    assign acc_done = acc_done_q;
    assign debug    = {1'b0, state_q, 12'h000, err_cnt};

endmodule

// File: tb/tb_axitrafficgen_axi_master.sv
// Scoreboard bench: a reference model predicts AW/W/AR traffic and error counts,
// a slave model with random backpressure serves the bus, a monitor compares handshakes.
module tb_axitrafficgen_axi_master;
    import axitrafficgen_pkg::*;

    localparam int BURST = 16;
`ifdef AXITRAFFICGEN_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    typedef struct {
        logic [31:0] addr;
        logic [7:0]  len;
    } ax_t;
    typedef struct {
        logic [63:0] data;
        logic        last;
    } w_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] reg1 = '0;
    logic [31:0] reg2 = '0;
    logic        conf_done = 1'b0;
    logic        acc_done;
    logic [31:0] debug;

    axitrafficgen_axi_master_if #(.AXI_ADDR_WIDTH(32), .AXI_DATA_WIDTH(64), .AXI_ID_WIDTH(4)) axi_if ();

    axitrafficgen_axi_master #(
        .AXI_ADDR_WIDTH(32), .AXI_DATA_WIDTH(64), .AXI_ID_WIDTH(4), .BURST_BEATS(BURST)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .conf_info_reg1 (reg1),
        .conf_info_reg2 (reg2),
        .conf_done      (conf_done),
        .axi            (axi_if),
        .acc_done       (acc_done),
        .debug          (debug)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;

    ax_t exp_aw[$];
    ax_t exp_ar[$];
    w_t  exp_w[$];

    // Slave behaviour knobs for the current run
    bit bp = 1'b0;
    int berr_start = -1;
    int rerr_a = -1;
    int rerr_b = -1;
    int corrupt_beat = -1;

    int acc_cnt = 0;
    int valid_cnt = 0;

    function automatic void check(string name, logic [127:0] act, logic [127:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endfunction

    // Reference model: split N beats into bursts of at most BURST, address = beat*8.
    function automatic void build_model(int n, logic [31:0] s);
        int i = 0;
        while (i < n) begin
            int l;
            l = (n - i > BURST) ? BURST : n - i;
            exp_aw.push_back('{32'(i * 8), 8'(l - 1)});
            exp_ar.push_back('{32'(i * 8), 8'(l - 1)});
            for (int k = 0; k < l; k++) exp_w.push_back('{{s, 32'(i + k)}, (k == l - 1)});
            i += l;
        end
    endfunction

    // ---------------- slave model ----------------
    logic [63:0] mem [int];
    ax_t s_wq[$];
    ax_t s_rq[$];
    int  s_bq[$];
    int  s_wk = 0;
    int  s_rk = 0;
    bit  s_bhs = 0;
    bit  s_rhs = 0;

    initial begin
        axi_if.aw_ready = 0; axi_if.w_ready = 0; axi_if.ar_ready = 0;
        axi_if.b_valid = 0; axi_if.b_resp = 0;
        axi_if.r_valid = 0; axi_if.r_data = 0; axi_if.r_resp = 0; axi_if.r_last = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                s_wq.delete(); s_rq.delete(); s_bq.delete();
                s_wk = 0; s_rk = 0; s_bhs = 0; s_rhs = 0;
                axi_if.aw_ready = 0; axi_if.w_ready = 0; axi_if.ar_ready = 0;
                axi_if.b_valid = 0; axi_if.r_valid = 0;
            end else begin
                // B before W so a response appears only after the last W handshake
                if (s_bhs) begin axi_if.b_valid = 0; s_bhs = 0; end
                if (!axi_if.b_valid && s_bq.size() > 0 && (!bp || $urandom_range(0, 1) == 1)) begin
                    int st;
                    st = s_bq.pop_front();
                    axi_if.b_valid = 1;
                    axi_if.b_resp  = (st == berr_start) ? 2'b10 : 2'b00;
                end
                s_bhs = axi_if.b_valid && axi_if.b_ready;

                axi_if.w_ready = bp ? ($urandom_range(0, 2) != 0) : 1'b1;
                if (axi_if.w_valid && axi_if.w_ready && s_wq.size() > 0) begin
                    mem[int'(s_wq[0].addr >> 3) + s_wk] = axi_if.w_data;
                    s_wk++;
                    if (axi_if.w_last) begin
                        s_bq.push_back(int'(s_wq[0].addr >> 3));
                        void'(s_wq.pop_front());
                        s_wk = 0;
                    end
                end

                axi_if.aw_ready = bp ? ($urandom_range(0, 2) != 0) : 1'b1;
                if (axi_if.aw_valid && axi_if.aw_ready) s_wq.push_back('{axi_if.aw_addr, axi_if.aw_len});

                if (s_rhs) begin
                    s_rhs = 0;
                    axi_if.r_valid = 0;
                    s_rk++;
                    if (s_rk > int'(s_rq[0].len)) begin void'(s_rq.pop_front()); s_rk = 0; end
                end
                if (!axi_if.r_valid && s_rq.size() > 0 && (!bp || $urandom_range(0, 1) == 1)) begin
                    int beat;
                    logic [63:0] d;
                    beat = int'(s_rq[0].addr >> 3) + s_rk;
                    d = mem.exists(beat) ? mem[beat] : 64'd0;
                    if (beat == corrupt_beat) d = d ^ 64'h1;
                    axi_if.r_valid = 1;
                    axi_if.r_data  = d;
                    axi_if.r_last  = (s_rk == int'(s_rq[0].len));
                    axi_if.r_resp  = (beat == rerr_a || beat == rerr_b) ? 2'b10 : 2'b00;
                end
                s_rhs = axi_if.r_valid && axi_if.r_ready;

                axi_if.ar_ready = bp ? ($urandom_range(0, 2) != 0) : 1'b1;
                if (axi_if.ar_valid && axi_if.ar_ready) s_rq.push_back('{axi_if.ar_addr, axi_if.ar_len});
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    bit           aw_st = 0, w_st = 0, ar_st = 0;
    logic [127:0] aw_prev, w_prev, ar_prev;

    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (rst) begin
                aw_st = 0; w_st = 0; ar_st = 0;
            end else begin
                logic [127:0] aw_now, w_now, ar_now;
                aw_now = {1'b1, axi_if.aw_valid, axi_if.aw_id, axi_if.aw_addr, axi_if.aw_len, axi_if.aw_size, axi_if.aw_burst};
                w_now  = {1'b1, axi_if.w_valid, axi_if.w_data, axi_if.w_strb, axi_if.w_last};
                ar_now = {1'b1, axi_if.ar_valid, axi_if.ar_id, axi_if.ar_addr, axi_if.ar_len, axi_if.ar_size, axi_if.ar_burst};
                if (acc_done) acc_cnt++;
                if (axi_if.aw_valid || axi_if.w_valid || axi_if.ar_valid || axi_if.b_ready || axi_if.r_ready) valid_cnt++;

                if (aw_st) check("aw_hold", aw_now, aw_prev);
                if (w_st)  check("w_hold", w_now, w_prev);
                if (ar_st) check("ar_hold", ar_now, ar_prev);

                if (axi_if.aw_valid && axi_if.aw_ready) begin
                    if (exp_aw.size() == 0) check("aw_unexpected", 1, 0);
                    else begin
                        ax_t e;
                        e = exp_aw.pop_front();
                        $display("AW addr=%h len=%0d", axi_if.aw_addr, axi_if.aw_len);
                        check("aw_beat", {axi_if.aw_id, axi_if.aw_addr, axi_if.aw_len, axi_if.aw_size, axi_if.aw_burst},
                              {4'h0, e.addr, e.len, 3'b011, 2'b01});
                    end
                end
                if (axi_if.w_valid && axi_if.w_ready) begin
                    if (exp_w.size() == 0) check("w_unexpected", 1, 0);
                    else begin
                        w_t e;
                        e = exp_w.pop_front();
                        $display("W  data=%h last=%0d", axi_if.w_data, axi_if.w_last);
                        check("w_beat", {axi_if.w_data, axi_if.w_strb, axi_if.w_last}, {e.data, 8'hFF, e.last});
                    end
                end
                if (axi_if.ar_valid && axi_if.ar_ready) begin
                    if (exp_ar.size() == 0) check("ar_unexpected", 1, 0);
                    else begin
                        ax_t e;
                        e = exp_ar.pop_front();
                        $display("AR addr=%h len=%0d", axi_if.ar_addr, axi_if.ar_len);
                        check("ar_beat", {axi_if.ar_id, axi_if.ar_addr, axi_if.ar_len, axi_if.ar_size, axi_if.ar_burst},
                              {4'h0, e.addr, e.len, 3'b011, 2'b01});
                    end
                end

                aw_st = axi_if.aw_valid && !axi_if.aw_ready; aw_prev = aw_now;
                w_st  = axi_if.w_valid && !axi_if.w_ready;   w_prev  = w_now;
                ar_st = axi_if.ar_valid && !axi_if.ar_ready; ar_prev = ar_now;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic run_case(input string tag, input int n, input logic [31:0] s, input bit bpv,
                            input int be, input int ra, input int rb, input int cb, input int exp_err);
        int  acc0;
        bit  seen = 0;
        bp = bpv; berr_start = be; rerr_a = ra; rerr_b = rb; corrupt_beat = cb;
        build_model(n, s);
        acc0 = acc_cnt;
        @(negedge clk);
        reg1 = 32'(n); reg2 = s; conf_done = 1;
        @(negedge clk);
        conf_done = 0;
        for (int c = 0; c < 6000; c++) begin
            if (acc_done) begin seen = 1; break; end
            @(negedge clk);
        end
        check({tag, "_acc_done"}, seen, 1);
        if (seen) begin
            check({tag, "_err_cnt"}, debug[15:0], 16'(exp_err));
            check({tag, "_state"}, debug[31:16], 16'h0000);
            @(negedge clk);
            check({tag, "_acc_pulse_len"}, acc_done, 0);
        end
        repeat (3) @(negedge clk);
        check({tag, "_acc_count"}, acc_cnt - acc0, 1);
        check({tag, "_queues_drained"}, exp_aw.size() + exp_w.size() + exp_ar.size(), 0);
        exp_aw.delete(); exp_w.delete(); exp_ar.delete();
        $display("RUN %s N=%0d seed=%h debug=%h expected_err=%0d", tag, n, s, debug, exp_err);
    endtask

    initial begin
        int v0, a0, n;
        logic [31:0] s;
        bit found;

        rst = 1;
        repeat (3) @(negedge clk);
        check("rst_valids", {axi_if.aw_valid, axi_if.w_valid, axi_if.ar_valid, axi_if.b_ready, axi_if.r_ready}, 5'b0);
        check("rst_acc_done", acc_done, 0);
        check("rst_debug", debug, 32'h0);
        rst = 0;

        run_case("n5", 5, 32'hA5A5_0000, 0, -1, -1, -1, -1, 0);
        run_case("n40", 40, $urandom, 0, -1, -1, -1, -1, 0);
        run_case("bp_err", 40, $urandom, 1, 16, 3, 33, -1, 3);

        // N=0 goes straight to DONE: pulse two cycles after conf_done, no bus activity
        v0 = valid_cnt; a0 = acc_cnt;
        @(negedge clk);
        reg1 = 0; conf_done = 1;
        @(negedge clk);
        conf_done = 0;
        check("n0_acc_c1", acc_done, 0);
        @(negedge clk);
        check("n0_acc_c2", acc_done, 1);
        @(negedge clk);
        check("n0_acc_c3", acc_done, 0);
        repeat (2) @(negedge clk);
        check("n0_no_valid", valid_cnt - v0, 0);
        check("n0_acc_count", acc_cnt - a0, 1);
        check("n0_debug", debug, 32'h0);

        run_case("corrupt7", 10, $urandom, 1, -1, -1, -1, 7, CHK ? 1 : 0);

        // Reset while the write data phase is in progress
        bp = 0; berr_start = -1; rerr_a = -1; rerr_b = -1; corrupt_beat = -1;
        build_model(40, 32'h1234_5678);
        @(negedge clk);
        reg1 = 40; reg2 = 32'h1234_5678; conf_done = 1;
        @(negedge clk);
        conf_done = 0;
        found = 0;
        for (int c = 0; c < 200; c++) begin
            if (debug[31:28] == 4'd2) begin found = 1; break; end
            @(negedge clk);
        end
        check("rstw_reach_w", found, 1);
        rst = 1;
        @(negedge clk);
        check("rstw_valids", {axi_if.aw_valid, axi_if.w_valid, axi_if.ar_valid, axi_if.b_ready, axi_if.r_ready}, 5'b0);
        check("rstw_debug", debug, 32'h0);
        check("rstw_acc_done", acc_done, 0);
        exp_aw.delete(); exp_w.delete(); exp_ar.delete();
        @(negedge clk);
        rst = 0;
        run_case("after_rst", 20, $urandom, 0, -1, -1, -1, -1, 0);

        for (int r = 0; r < 6; r++) begin
            int be, ra, rb, cb, nb, e;
            n  = $urandom_range(3, 60);
            s  = $urandom;
            nb = (n + BURST - 1) / BURST;
            be = ($urandom_range(0, 1) == 1) ? BURST * $urandom_range(0, nb - 1) : -1;
            ra = $urandom_range(0, n - 1);
            rb = (ra + 1) % n;
            cb = ($urandom_range(0, 1) == 1) ? (ra + 2) % n : -1;
            e  = (be >= 0 ? 1 : 0) + 2 + ((cb >= 0 && CHK) ? 1 : 0);
            run_case("rand", n, s, 1, be, ra, rb, cb, e);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
